fifo_sync_ctrl: RTL and testbench

//  Single-clock sequencer for the dual-port `ram` storage array in the FIFO datapath.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ptr.sv | 35 +++
 rtl/fifo_sync_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fifo_sync_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encodings for the FIFO controller family
package fifo_pkg;

  // Occupancy state of the sequencer; the full/empty flags decode directly from it
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-bit pointer counter used for the FIFO write and read sides
module fifo_ptr #(
  parameter int FIFO_DEPTH_BIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  output logic [FIFO_DEPTH_BIT:0] ptr
);

  localparam logic [FIFO_DEPTH_BIT:0] PTR_ONE = (FIFO_DEPTH_BIT + 1)'(1);

  logic [FIFO_DEPTH_BIT:0] ptr_q;
  logic [FIFO_DEPTH_BIT:0] ptr_d;

  // Advance by one per accepted op; binary rollover wraps 2*DEPTH-1 back to 0
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = ptr_q + PTR_ONE;
    end
  end

  // Pointer register, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO sequencer for a dual-port RAM; FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_DEPTH_BIT = 4
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AFULL_TH       = 12,
  parameter int AEMPTY_TH      = 2
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    err_clr,
  output logic                    w_en,
  output logic                    r_en,
  output logic [FIFO_DEPTH_BIT-1:0] write_addr,
  output logic [FIFO_DEPTH_BIT-1:0] read_addr,
  output logic                    flag_full,
  output logic                    flag_empty,
  output logic [FIFO_DEPTH_BIT:0] fifo_count,
  output logic                    rd_valid,
  output logic                    overflow,
  output logic                    underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                    almost_full,
  output logic                    almost_empty
`endif
);

  localparam logic [FIFO_DEPTH_BIT:0] CNT_ONE   = (FIFO_DEPTH_BIT + 1)'(1);
  localparam logic [FIFO_DEPTH_BIT:0] CNT_LAST  = (FIFO_DEPTH_BIT + 1)'(FIFO_DEPTH - 1);
`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [FIFO_DEPTH_BIT:0] CNT_AFULL = (FIFO_DEPTH_BIT + 1)'(AFULL_TH);
  localparam logic [FIFO_DEPTH_BIT:0] CNT_AEMPT = (FIFO_DEPTH_BIT + 1)'(AEMPTY_TH);
  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;
`endif

  fifo_state_e             state_q, state_d;
  logic [FIFO_DEPTH_BIT:0] count_q, count_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic [FIFO_DEPTH_BIT:0] wr_ptr, rd_ptr;
  logic                    push_ok, pop_ok;

  assign flag_full  = (state_q == ST_FULL);
  assign flag_empty = (state_q == ST_EMPTY);

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle;
  // a pop on empty is never accepted, so there is no write-to-read bypass
  assign push_ok = push & (~flag_full | pop);
  assign pop_ok  = pop & ~flag_empty;

  fifo_ptr #(.FIFO_DEPTH_BIT(FIFO_DEPTH_BIT)) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (push_ok),
    .ptr  (wr_ptr)
  );

  fifo_ptr #(.FIFO_DEPTH_BIT(FIFO_DEPTH_BIT)) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pop_ok),
    .ptr  (rd_ptr)
  );

  // Next occupancy, state, strobes and sticky errors; an error set beats err_clr
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_ok) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (push_ok && !pop_ok && count_q == CNT_LAST) begin
          state_d = ST_FULL;
        end else if (pop_ok && !push_ok && count_q == CNT_ONE) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_ok && !push_ok) state_d = ST_ACTIVE;
      end
      default: state_d = ST_EMPTY;
    endcase

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end

    rd_valid_d = pop_ok;

    overflow_d = overflow_q;
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end

    underflow_d = underflow_q;
    if (pop && flag_empty) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    almost_full_d  = (count_d >= CNT_AFULL);
    almost_empty_d = (count_d <= CNT_AEMPT);
`endif
  end

  // Controller registers; reset discards all contents and returns to EMPTY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_EMPTY;
      count_q        <= '0;
      rd_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rd_valid_q     <= rd_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
`ifdef FIFO_ALMOST_FLAGS_EN
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
`endif
    end
  end

  // Occupancy must always equal the modular distance between the two pointers
  assert property (@(posedge clk) disable iff (!rst_n) count_q == wr_ptr - rd_ptr);

  assign w_en       = push_ok;
  assign r_en       = pop_ok;
  assign write_addr = wr_ptr[FIFO_DEPTH_BIT-1:0];
  assign read_addr  = rd_ptr[FIFO_DEPTH_BIT-1:0];
  assign fifo_count = count_q;
  assign rd_valid   = rd_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - scoreboard bench for fifo_sync_ctrl with a queue-based reference model
module tb_fifo_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        err_clr = 1'b0;
  logic        w_en, r_en;
  logic [3:0]  write_addr, read_addr;
  logic        flag_full, flag_empty;
  logic [4:0]  fifo_count;
  logic        rd_valid, overflow, underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic        almost_full, almost_empty;
`endif

  fifo_sync_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .pop         (pop),
    .err_clr     (err_clr),
    .w_en        (w_en),
    .r_en        (r_en),
    .write_addr  (write_addr),
    .read_addr   (read_addr),
    .flag_full   (flag_full),
    .flag_empty  (flag_empty),
    .fifo_count  (fifo_count),
    .rd_valid    (rd_valid),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM driven by the controller's strobes and addresses
  logic [15:0] mem [16];
  logic [15:0] wdata = 16'd0;
  logic [15:0] rdata;
  always @(posedge clk) begin
    if (w_en) mem[write_addr] <= wdata;
    if (r_en) rdata <= mem[read_addr];
  end

  typedef struct packed {
    logic       w_en;
    logic       r_en;
    logic [3:0] wa;
    logic [3:0] ra;
    logic       full;
    logic       empty;
    logic [4:0] cnt;
    logic       rdv;
    logic       ovf;
    logic       unf;
    logic       af;
    logic       ae;
    logic [4:0] wp;
  } obs_t;

  obs_t        exp_q[$];
  logic [15:0] rd_exp[$];
  logic [15:0] mq[$];
  int          wcnt, rcnt;
  bit          ovf_m, unf_m, rdv_m;
  int          checks = 0;
  int          errors = 0;

  function automatic obs_t snapshot();
    obs_t a;
    a.w_en  = w_en;
    a.r_en  = r_en;
    a.wa    = write_addr;
    a.ra    = read_addr;
    a.full  = flag_full;
    a.empty = flag_empty;
    a.cnt   = fifo_count;
    a.rdv   = rd_valid;
    a.ovf   = overflow;
    a.unf   = underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    a.af    = almost_full;
    a.ae    = almost_empty;
`else
    a.af    = 1'b0;
    a.ae    = 1'b0;
`endif
    a.wp    = dut.wr_ptr;
    return a;
  endfunction

  task automatic model_reset();
    mq.delete();
    rd_exp.delete();
    wcnt  = 0;
    rcnt  = 0;
    ovf_m = 1'b0;
    unf_m = 1'b0;
    rdv_m = 1'b0;
  endtask

  // Assert reset for one cycle and expect the documented reset outputs
  task automatic reset_cycle();
    obs_t e;
    @(negedge clk);
    rst_n   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    model_reset();
    e = '0;
    e.empty = 1'b1;
`ifdef FIFO_ALMOST_FLAGS_EN
    e.ae = 1'b1;
`endif
    exp_q.push_back(e);
  endtask

  // One request cycle: predict outputs from the occupancy queue, then advance the model
  task automatic step(input bit p, input bit q, input bit c, input logic [15:0] d);
    obs_t e;
    bit   full, empty, pok, qok;
    int   n;
    @(negedge clk);
    rst_n   = 1'b1;
    push    = p;
    pop     = q;
    err_clr = c;
    wdata   = d;
    n     = mq.size();
    full  = (n == 16);
    empty = (n == 0);
    pok   = p && (!full || q);
    qok   = q && !empty;
    e.w_en  = pok;
    e.r_en  = qok;
    e.wa    = 4'(wcnt % 16);
    e.ra    = 4'(rcnt % 16);
    e.full  = full;
    e.empty = empty;
    e.cnt   = 5'(n);
    e.rdv   = rdv_m;
    e.ovf   = ovf_m;
    e.unf   = unf_m;
`ifdef FIFO_ALMOST_FLAGS_EN
    e.af    = (n >= 12);
    e.ae    = (n <= 2);
`else
    e.af    = 1'b0;
    e.ae    = 1'b0;
`endif
    e.wp    = 5'(wcnt % 32);
    exp_q.push_back(e);
    if (qok) begin
      rd_exp.push_back(mq.pop_front());
      rcnt++;
    end
    if (pok) begin
      mq.push_back(d);
      wcnt++;
    end
    if (p && !pok) ovf_m = 1'b1;
    else if (c)    ovf_m = 1'b0;
    if (q && empty) unf_m = 1'b1;
    else if (c)     unf_m = 1'b0;
    rdv_m = qok;
  endtask

  // Monitor: compare every predicted cycle and every valid read word
  initial begin
    obs_t        e, a;
    logic [15:0] d;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = snapshot();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got=%h required=%h (w_en r_en wa ra full empty cnt rdv ovf unf af ae wp)",
                   $time, a, e);
        end
      end
      if (rd_valid === 1'b1) begin
        checks++;
        if (rd_exp.size() == 0) begin
          errors++;
          $display("FAIL rd_data t=%0t got=%h required=no read outstanding", $time, rdata);
        end else begin
          d = rd_exp.pop_front();
          if (rdata !== d) begin
            errors++;
            $display("FAIL rd_data t=%0t got=%h required=%h", $time, rdata, d);
          end
        end
      end
    end
  end

  initial begin
    int bias;
    reset_cycle();
    reset_cycle();

    // Fill to full, first word 100
    step(1, 0, 0, 16'd100);
    for (int i = 1; i < 16; i++) step(1, 0, 0, 16'($urandom));

    // Overflow is sticky, a simultaneous set beats err_clr, then it clears
    step(1, 0, 0, 16'hdead);
    step(0, 0, 0, 16'd0);
    step(1, 0, 1, 16'hbeef);
    step(0, 0, 0, 16'd0);
    step(0, 0, 1, 16'd0);
    step(0, 0, 0, 16'd0);

    // Drain in write order
    for (int i = 0; i < 16; i++) step(0, 1, 0, 16'd0);
    step(0, 0, 0, 16'd0);

    // Underflow, then push+pop on empty
    step(0, 1, 0, 16'd0);
    step(1, 1, 0, 16'h1234);
    step(0, 0, 0, 16'd0);
    step(0, 0, 1, 16'd0);

    // Fill to 16, then simultaneous traffic across the address wrap
    for (int i = 0; i < 15; i++) step(1, 0, 0, 16'($urandom));
    for (int i = 0; i < 20; i++) step(1, 1, 0, 16'($urandom));
    for (int i = 0; i < 16; i++) step(0, 1, 0, 16'd0);

    // Randomized traffic with varying fill bias and a mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) bias = (i / 50) % 3 == 0 ? 80 : ((i / 50) % 3 == 1 ? 50 : 20);
      if (i == 210) reset_cycle();
      else step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
                $urandom_range(0, 15) == 0, 16'($urandom));
    end

    step(0, 0, 0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    #5;
    checks++;
    if (rd_exp.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d reads %0d cycles pending required=0", rd_exp.size(), exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
